// File: rtl/load_store_unit.sv
// Byte-addressed RV32 load/store front end driving a word-wide data memory (MEM stage).
// Latency: response 1 cycle after the final memory access; SB/SH take 2 cycles (read, then merged write).
// Backpressure: req_ready drops for the one RMW write cycle; responses cannot be stalled.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state, state_nxt;
  logic              xfer;
  logic              f_b, f_h, f_w, f_bu, f_hu;
  logic              legal_f3, misal, fault;
  logic              is_load, is_sw, is_sub_st;
  logic [4:0]        shamt;
  logic [31:0]       rd_shift, ld_ext, st_mask, st_data, merge_nxt;
  logic [31:0]       merge_q;
  logic [ADDR_W-3:0] waddr_q;

  // Requests are only taken in IDLE; the RMW write cycle owns the memory port.
  assign xfer = req_valid & (state == IDLE);

  // Decode the access and work out load extraction and the sub-word store merge.
  always_comb begin
    f_b      = (req_funct3 == 3'b000);
    f_h      = (req_funct3 == 3'b001);
    f_w      = (req_funct3 == 3'b010);
    f_bu     = (req_funct3 == 3'b100);
    f_hu     = (req_funct3 == 3'b101);
    // Unsigned variants only exist for loads.
    legal_f3 = req_write ? (f_b | f_h | f_w) : (f_b | f_h | f_w | f_bu | f_hu);
    misal    = ((f_h | f_hu) & req_addr[0]) | (f_w & (req_addr[1:0] != 2'b00));
    fault    = ~legal_f3 | misal;
    is_load  = ~req_write & ~fault;
    is_sw    = req_write & f_w & ~fault;
    is_sub_st = req_write & (f_b | f_h) & ~fault;

    shamt    = {req_addr[1:0], 3'b000};
    rd_shift = mem_rdata >> shamt;
    ld_ext   = 32'h0;
    case (req_funct3)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_ext = mem_rdata;
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = 32'h0;
    endcase

    st_mask   = (f_b ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    st_data   = (f_b ? {24'h0, req_wdata[7:0]} : {16'h0, req_wdata[15:0]}) << shamt;
    merge_nxt = (mem_rdata & ~st_mask) | (st_data & st_mask);
  end

  // State register; async reset abandons any pending RMW write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: only an accepted, legal sub-word store enters the write-back cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && is_sub_st) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port and handshake outputs, combinational from state and the live request.
  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = req_addr[ADDR_W-1:2];
    mem_wdata = req_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        mem_read  = req_valid & (is_load | is_sub_st);
        mem_write = req_valid & is_sw;
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = merge_q;
      end
      default: ;
    endcase
  end

  // Hold the merged word and its address across the read-to-write boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_q <= 32'h0;
      waddr_q <= '0;
    end else if (xfer && is_sub_st) begin
      merge_q <= merge_nxt;
      waddr_q <= req_addr[ADDR_W-1:2];
    end
  end

  // Response one cycle after the last memory access; sub-word stores answer from RMW_WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid      <= (xfer & ~is_sub_st) | (state == RMW_WR);
      resp_misaligned <= xfer & fault;
      resp_rdata      <= (xfer && is_load) ? ld_ext : 32'h0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, scoreboard of expected responses with arrival cycle.
// Latency: responses expected 1 cycle (2 for SB/SH) after acceptance, checked against a cycle counter.
// Backpressure: driver holds a request until req_ready is seen, counting stall cycles.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, write on posedge, plus a bench-side preload port.
  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_dat;
  always @(posedge clk) begin
    if (bd_we)          mem[bd_addr]  <= bd_dat;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  // Response monitor: every response must match the oldest expectation, on its cycle.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
        chk("resp_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_dat  = d;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  // Present one request, wait for acceptance, check the memory strobes in the accept cycle.
  task automatic send(input logic w, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                      input logic exp_mr, input logic exp_mw, input int lat, output int waits);
    bit acc;
    exp_t e;
    acc        = 1'b0;
    waits      = 0;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        chk("mem_read", 32'(mem_read), 32'(exp_mr));
        chk("mem_write", 32'(mem_write), 32'(exp_mw));
        chk("mem_addr", 32'(mem_addr), 32'(a[7:2]));
        if (exp_mw) chk("mem_wdata", mem_wdata, wd);
        e.rd  = exp_rd;
        e.mis = exp_mis;
        e.at  = cyc + lat;
        sb_q.push_back(e);
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 8'h0;
    req_wdata  = 32'h0;
    bd_we      = 1'b0;
    bd_addr    = 6'h0;
    bd_dat     = 32'h0;
    #2 rst_n = 1'b0;

    // Reset state
    preload(6'd0, 32'h80FF7F01);
    preload(6'd1, 32'h00000009);
    preload(6'd2, 32'h00000000);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_mis", 32'(resp_misaligned), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: load extraction and extension from word0 = 0x80FF7F01
    send(1'b0, 3'b000, 8'd1, 32'h0, 32'h0000007F, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b000, 8'd2, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b100, 8'd2, 32'h0, 32'h000000FF, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b001, 8'd2, 32'h0, 32'hFFFF80FF, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b101, 8'd2, 32'h0, 32'h000080FF, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b000, 8'd3, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b010, 8'd0, 32'h0, 32'h80FF7F01, 1'b0, 1'b1, 1'b0, 1, w);

    // 2: SB 0xAB@5 read-modify-write into word1 = 9
    send(1'b1, 3'b000, 8'd5, 32'h000000AB, 32'h0, 1'b0, 1'b1, 1'b0, 2, w);
    @(negedge clk);
    chk("rmw_req_ready", 32'(req_ready), 32'd0);
    chk("rmw_mem_write", 32'(mem_write), 32'd1);
    chk("rmw_mem_read", 32'(mem_read), 32'd0);
    chk("rmw_mem_addr", 32'(mem_addr), 32'd1);
    chk("rmw_mem_wdata", mem_wdata, 32'h0000AB09);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmw_ready_back", 32'(req_ready), 32'd1);
    chk("rmw_word1", mem[1], 32'h0000AB09);
    @(posedge clk); #1;
    send(1'b0, 3'b010, 8'd4, 32'h0, 32'h0000AB09, 1'b0, 1'b1, 1'b0, 1, w);
    // Request held behind an RMW write sees the merged word
    send(1'b1, 3'b000, 8'd4, 32'h00000011, 32'h0, 1'b0, 1'b1, 1'b0, 2, w);
    send(1'b0, 3'b010, 8'd4, 32'h0, 32'h0000AB11, 1'b0, 1'b1, 1'b0, 1, w);
    chk("held_stall", 32'(w), 32'd1);
    send(1'b1, 3'b001, 8'd6, 32'hFFFF1234, 32'h0, 1'b0, 1'b1, 1'b0, 2, w);
    send(1'b0, 3'b001, 8'd6, 32'h0, 32'h00001234, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b010, 8'd4, 32'h0, 32'h1234AB11, 1'b0, 1'b1, 1'b0, 1, w);
    chk("sh_no_stall", 32'(w), 32'd0);

    // 3: SW writes in the accept cycle, no stall
    send(1'b1, 3'b010, 8'd8, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, 1, w);
    send(1'b0, 3'b010, 8'd8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1, w);
    chk("sw_no_stall", 32'(w), 32'd0);

    // 4: faults leave memory untouched
    send(1'b0, 3'b010, 8'd6, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1, w);
    send(1'b1, 3'b001, 8'd3, 32'h00005555, 32'h0, 1'b1, 1'b0, 1'b0, 1, w);
    send(1'b0, 3'b011, 8'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1, w);
    send(1'b1, 3'b100, 8'd0, 32'h00000077, 32'h0, 1'b1, 1'b0, 1'b0, 1, w);
    send(1'b0, 3'b001, 8'd1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1, w);
    chk("fault_word0", mem[0], 32'h80FF7F01);
    chk("fault_word1", mem[1], 32'h1234AB11);

    // 5: async reset during the RMW write cycle
    repeat (2) @(posedge clk);
    #1;
    chk("drain_before_rst", 32'(sb_q.size()), 32'd0);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 8'd0;
    req_wdata  = 32'h00001234;
    @(negedge clk);
    chk("rst_sh_ready", 32'(req_ready), 32'd1);
    chk("rst_sh_read", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_sh_rmw_write", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mid_resp_mis", 32'(resp_misaligned), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_word0", mem[0], 32'h80FF7F01);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 6: back-to-back word loads, one response per cycle
    preload(6'd0, 32'd17);
    preload(6'd1, 32'd9);
    preload(6'd2, 32'd25);
    send(1'b0, 3'b010, 8'd0, 32'h0, 32'd17, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b010, 8'd4, 32'h0, 32'd9, 1'b0, 1'b1, 1'b0, 1, w);
    send(1'b0, 3'b010, 8'd8, 32'h0, 32'd25, 1'b0, 1'b1, 1'b0, 1, w);
    chk("b2b_no_stall", 32'(w), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("drain_final", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
